// File: rtl/sbox_sched_if.sv
// Handshake and data bundle between the two S-box requesters and the scheduler.
// master = requester side (round controller / key expansion), slave = scheduler.
interface sbox_sched_if;
  logic         state_valid;
  logic         state_ready;
  logic [127:0] state_in;
  logic         state_done;
  logic [127:0] state_out;
  logic         word_valid;
  logic         word_ready;
  logic [31:0]  word_in;
  logic         word_done;
  logic [31:0]  word_out;
  logic         busy;

  modport master (
    output state_valid, state_in, word_valid, word_in,
    input  state_ready, state_done, state_out, word_ready, word_done, word_out, busy
  );

  modport slave (
    input  state_valid, state_in, word_valid, word_in,
    output state_ready, state_done, state_out, word_ready, word_done, word_out, busy
  );
endinterface

// File: rtl/sbox_scheduler.sv
// Shares one 4-byte AES S-box lane between SubBytes (128-bit state, one column
// per cycle) and SubWord (32-bit word, one cycle), with round-robin tie-breaking.

module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Byte x of the forward AES S-box lives at bits [8*(255-x) +: 8].
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX_TABLE[{~a, 3'b000} +: 8];
endmodule

// state   | meaning
// IDLE    | waiting for a request; the only state in which ready can be high
// ST_RUN  | substituting state_buf column cnt, written back in place
// WD_RUN  | substituting word_buf, result captured into word_out
// ST_DONE | state_done pulse
// WD_DONE | word_done pulse
module sbox_scheduler #(
  parameter bit WORD_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  sbox_sched_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ST_RUN, WD_RUN, ST_DONE, WD_DONE} fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         last_grant_q, last_grant_d;
  logic [127:0] state_buf_q, state_buf_d;
  logic [127:0] state_out_q, state_out_d;
  logic [31:0]  word_buf_q, word_buf_d;
  logic [31:0]  word_out_q, word_out_d;
  logic [31:0]  lane_in, lane_out;
  logic         idle;

  assign idle           = (fsm_q == IDLE);
  assign bus.word_ready  = idle & (~bus.state_valid | ~last_grant_q);
  assign bus.state_ready = idle & (~bus.word_valid | last_grant_q);
  assign bus.state_done  = (fsm_q == ST_DONE);
  assign bus.word_done   = (fsm_q == WD_DONE);
  assign bus.state_out   = state_out_q;
  assign bus.word_out    = word_out_q;
  assign bus.busy        = ~idle;

  // Column c of the state occupies bits [32*(3-c) +: 32].
  assign lane_in = (fsm_q == ST_RUN) ? state_buf_q[{~cnt_q, 5'b00000} +: 32] : word_buf_q;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    sbox u_sbox (.a(lane_in[8*i +: 8]), .y(lane_out[8*i +: 8]));
  end

  always_comb begin
    fsm_d        = fsm_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    state_buf_d  = state_buf_q;
    state_out_d  = state_out_q;
    word_buf_d   = word_buf_q;
    word_out_d   = word_out_q;
    unique case (fsm_q)
      IDLE: begin
        if (bus.word_valid && bus.word_ready) begin
          word_buf_d   = bus.word_in;
          last_grant_d = 1'b1;
          fsm_d        = WD_RUN;
        end else if (bus.state_valid && bus.state_ready) begin
          state_buf_d  = bus.state_in;
          cnt_d        = 2'd0;
          last_grant_d = 1'b0;
          fsm_d        = ST_RUN;
        end
      end
      ST_RUN: begin
        state_buf_d[{~cnt_q, 5'b00000} +: 32] = lane_out;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_out_d = state_buf_d;
          fsm_d       = ST_DONE;
        end
      end
      WD_RUN: begin
        word_out_d = lane_out;
        fsm_d      = WD_DONE;
      end
      ST_DONE, WD_DONE: fsm_d = IDLE;
      default:          fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q        <= IDLE;
      cnt_q        <= 2'd0;
      last_grant_q <= ~WORD_FIRST;
      state_buf_q  <= '0;
      state_out_q  <= '0;
      word_buf_q   <= '0;
      word_out_q   <= '0;
    end else begin
      fsm_q        <= fsm_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      state_buf_q  <= state_buf_d;
      state_out_q  <= state_out_d;
      word_buf_q   <= word_buf_d;
      word_out_q   <= word_out_d;
    end
  end
endmodule

// File: tb/tb_sbox_scheduler.sv
// Scoreboard bench for sbox_scheduler: expected results are queued at accept
// and compared when the matching done pulse appears.
module tb_sbox_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sbox_sched_if bus ();
  sbox_scheduler #(.WORD_FIRST(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  localparam logic [127:0] ST_V1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ST_R1 = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [31:0]  WD_V1 = 32'hcf4f3c09;
  localparam logic [31:0]  WD_R1 = 32'h8a84eb01;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_st_acc = 0, n_wd_acc = 0, n_st_done = 0, n_wd_done = 0, n_abort = 0;
  logic [127:0] exp_state[$];
  logic [31:0]  exp_word[$];

  int   acc_n;
  int   acc_cyc[4];
  logic acc_is_word[4];
  int   acc_delta[4] = '{0, 3, 9, 12};
  int   wd_done_cyc, st_done_cyc, ready_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push_state(input logic [127:0] e);
    exp_state.push_back(e);
    n_st_acc++;
  endtask

  task automatic push_word(input logic [31:0] e);
    exp_word.push_back(e);
    n_wd_acc++;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 30 && bus.busy; t++) tick();
    check("wait_idle", bus.busy, 1'b0);
  endtask

  task automatic run_state(input logic [127:0] din, input logic [127:0] e);
    int t;
    bus.state_in    = din;
    bus.state_valid = 1'b1;
    settle();
    for (t = 0; t < 20 && !bus.state_ready; t++) begin
      tick();
      settle();
    end
    check("run_state_ready", bus.state_ready, 1'b1);
    if (bus.state_ready) push_state(e);
    tick();
    bus.state_valid = 1'b0;
    wait_idle();
    tick();
  endtask

  task automatic run_word(input logic [31:0] din, input logic [31:0] e);
    int t;
    bus.word_in    = din;
    bus.word_valid = 1'b1;
    settle();
    for (t = 0; t < 20 && !bus.word_ready; t++) begin
      tick();
      settle();
    end
    check("run_word_ready", bus.word_ready, 1'b1);
    if (bus.word_ready) push_word(e);
    tick();
    bus.word_valid = 1'b0;
    wait_idle();
    tick();
  endtask

  // Scoreboard side: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      check("done_overlap", bus.state_done & bus.word_done, 1'b0);
      if (bus.state_done) begin
        n_st_done++;
        check("state_q_nonempty", exp_state.size() != 0, 1'b1);
        if (exp_state.size() != 0) check("state_out", bus.state_out, exp_state.pop_front());
      end
      if (bus.word_done) begin
        n_wd_done++;
        check("word_q_nonempty", exp_word.size() != 0, 1'b1);
        if (exp_word.size() != 0) check("word_out", bus.word_out, exp_word.pop_front());
      end
    end
  end

  initial begin
    rst_n           = 1'b0;
    bus.state_valid = 1'b0;
    bus.word_valid  = 1'b0;
    bus.state_in    = '0;
    bus.word_in     = '0;
    tick();
    tick();
    settle();
    check("rst_busy", bus.busy, 1'b0);
    check("rst_state_out", bus.state_out, '0);
    check("rst_word_out", bus.word_out, '0);
    check("rst_state_done", bus.state_done, 1'b0);
    check("rst_word_done", bus.word_done, 1'b0);
    check("rst_state_ready", bus.state_ready, 1'b1);
    check("rst_word_ready", bus.word_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // single state job; input toggled right after accept must not matter
    bus.state_in    = ST_V1;
    bus.state_valid = 1'b1;
    settle();
    check("t1_state_ready", bus.state_ready, 1'b1);
    push_state(ST_R1);
    tick();
    bus.state_valid = 1'b0;
    bus.state_in    = {128{1'b1}};
    for (int k = 1; k <= 5; k++) begin
      check("t1_busy", bus.busy, 1'b1);
      check("t1_state_done", bus.state_done, k == 5);
      tick();
    end
    check("t1_idle", bus.busy, 1'b0);
    check("t1_state_out_hold", bus.state_out, ST_R1);

    // single word job
    bus.word_in    = WD_V1;
    bus.word_valid = 1'b1;
    settle();
    check("t2_word_ready", bus.word_ready, 1'b1);
    push_word(WD_R1);
    tick();
    bus.word_valid = 1'b0;
    check("t2_word_done_c1", bus.word_done, 1'b0);
    tick();
    check("t2_word_done_c2", bus.word_done, 1'b1);
    check("t2_state_out_kept", bus.state_out, ST_R1);
    tick();
    check("t2_idle", bus.busy, 1'b0);

    // tie after reset: word first, then strict alternation
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t3_rst_state_out", bus.state_out, '0);
    bus.state_in    = ST_V1;
    bus.word_in     = WD_V1;
    bus.state_valid = 1'b1;
    bus.word_valid  = 1'b1;
    acc_n       = 0;
    wd_done_cyc = -1;
    st_done_cyc = -1;
    for (int t = 0; t < 60 && acc_n < 4; t++) begin
      settle();
      if (bus.word_done && wd_done_cyc < 0) wd_done_cyc = cyc;
      if (bus.state_done && st_done_cyc < 0) st_done_cyc = cyc;
      if (bus.word_valid && bus.word_ready) begin
        acc_is_word[acc_n] = 1'b1;
        acc_cyc[acc_n]     = cyc;
        acc_n++;
        push_word(WD_R1);
      end else if (bus.state_valid && bus.state_ready) begin
        acc_is_word[acc_n] = 1'b0;
        acc_cyc[acc_n]     = cyc;
        acc_n++;
        push_state(ST_R1);
      end
      tick();
    end
    bus.state_valid = 1'b0;
    bus.word_valid  = 1'b0;
    check("t3_accept_count", acc_n, 4);
    for (int i = 0; i < acc_n; i++) begin
      check("t3_grant_order", acc_is_word[i], (i % 2) == 0);
      check("t3_accept_cycle", acc_cyc[i] - acc_cyc[0], acc_delta[i]);
    end
    check("t3_word_done_cycle", wd_done_cyc - acc_cyc[0], 2);
    check("t3_state_done_cycle", st_done_cyc - acc_cyc[0], 8);
    wait_idle();
    tick();

    // word request held while a state job runs
    bus.state_in    = ST_V1;
    bus.state_valid = 1'b1;
    settle();
    check("t4_state_ready", bus.state_ready, 1'b1);
    push_state(ST_R1);
    tick();
    bus.state_valid = 1'b0;
    tick();
    bus.word_in    = WD_V1;
    bus.word_valid = 1'b1;
    ready_cyc      = -1;
    for (int t = 2; t < 20; t++) begin
      settle();
      if (bus.word_ready) begin
        ready_cyc = t;
        break;
      end
      tick();
    end
    check("t4_word_accept_cycle", ready_cyc, 6);
    if (ready_cyc >= 0) push_word(WD_R1);
    tick();
    bus.word_valid = 1'b0;
    check("t4_word_done_c7", bus.word_done, 1'b0);
    tick();
    check("t4_word_done_c8", bus.word_done, 1'b1);
    tick();
    wait_idle();

    // reset in the middle of a state job
    bus.state_in    = ST_V1;
    bus.state_valid = 1'b1;
    settle();
    check("t5_state_ready", bus.state_ready, 1'b1);
    push_state(ST_R1);
    tick();
    bus.state_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    exp_state.delete();
    n_abort++;
    tick();
    check("t5_busy", bus.busy, 1'b0);
    check("t5_state_out", bus.state_out, '0);
    check("t5_state_done", bus.state_done, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t5_no_done", bus.state_done, 1'b0);
    end

    // fresh jobs after the abort, including all-ones and all-zeros data
    run_state(ST_V1, ST_R1);
    run_state({128{1'b1}}, {16{8'h16}});
    run_state(128'h0, {16{8'h63}});
    run_word(32'h0, 32'h63636363);
    check("final_state_out", bus.state_out, {16{8'h63}});

    check("sb_state_empty", exp_state.size(), 0);
    check("sb_word_empty", exp_word.size(), 0);
    check("state_pulse_count", n_st_done, n_st_acc - n_abort);
    check("word_pulse_count", n_wd_done, n_wd_acc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sbox_scheduler.md
Name: sbox_scheduler

Overview:
Shares one 4-byte S-box lane (four `sbox` instances) between two requesters: the cipher round's SubBytes on a 128-bit state, and key expansion's SubWord on a 32-bit word. A full state is processed one column per cycle over 4 cycles. A word is processed in 1 cycle. Requesters use valid/ready handshakes, and a round-robin arbiter resolves ties. The block sits between the round controller and key-expansion unit and the S-box datapath.

Parameters:
WORD_FIRST, 1, requester that wins the first tie after reset: 1 = word, 0 = state.

Ports:
clk  in  1  single clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
state_valid  in  1  SubBytes request
state_ready  out  1  SubBytes request accepted when valid & ready at clock edge
state_in  in  128  state; byte k = state_in[127-8k -: 8]; column c = state_in[127-32c -: 32]
state_done  out  1  one-cycle pulse, state_out newly valid
state_out  out  128  SubBytes result, same byte mapping as state_in
word_valid  in  1  SubWord request
word_ready  out  1  SubWord request accepted when valid & ready at clock edge
word_in  in  32  word; byte k = word_in[31-8k -: 8]
word_done  out  1  one-cycle pulse, word_out newly valid
word_out  out  32  SubWord result, same byte mapping
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- FSM states: IDLE, ST_RUN, WD_RUN, ST_DONE, WD_DONE. Column counter cnt, 2 bits. last_grant flag: 1 = word granted last.
- Reset (rst_n=0 at edge):
  - FSM = IDLE, cnt = 0.
  - last_grant = ~WORD_FIRST.
  - state_out = 0, word_out = 0, state_done = 0, word_done = 0, internal buffers = 0.
  - Reset mid-operation abandons the job: no done pulse, results zeroed.
- Ready logic (combinational, asserted only in IDLE):
  - word_ready = IDLE & (~state_valid | ~last_grant)
  - state_ready = IDLE & (~word_valid | last_grant)
  - Exactly one request is accepted per edge, never both. With only one requester valid, it is always ready in IDLE.
- State accept (cycle c):
  - state_buf <= state_in, cnt <= 0, last_grant <= 0, go to ST_RUN.
  - In ST_RUN, the lane input is state_buf column cnt. The result is written back into state_buf column cnt each edge, and cnt increments.
  - On the edge where cnt==3: state_out <= final buffer (including column 3 result), go to ST_DONE.
  - ST_DONE: state_done=1 for one cycle, then IDLE.
  - Timeline: RUN occupies cycles c+1..c+4, state_done is high in cycle c+5. Next accept is possible in cycle c+6.
- Word accept (cycle c):
  - word_buf <= word_in, last_grant <= 1, go to WD_RUN.
  - WD_RUN (cycle c+1): lane input = word_buf. word_out <= lane result at end of cycle, go to WD_DONE.
  - WD_DONE: word_done=1 in cycle c+2, then IDLE.
- Lane mux: selects state_buf column when FSM=ST_RUN, otherwise word_buf. Purely combinational into the four sbox lookups. No arithmetic beyond 2-bit cnt wrap (3 -> 0 is not used; cnt reloads on accept).
- Outputs:
  - state_out and word_out hold their last value until overwritten by the next completion of the same type.
  - Inputs are sampled only at accept. Changes afterwards do not affect the job in flight.
- Requests made while busy:
  - A requester may hold valid while busy; ready stays 0 and nothing is dropped.
  - Deasserting valid before acceptance withdraws the request.
- Done pulses never overlap, and each job produces exactly one pulse.

Test Plan:
1. Reset then single state: state_in=00112233445566778899aabbccddeeff, valid held 1 cycle.
   -> state_ready=1 in cycle c; busy c+1..c+5; state_done only in c+5; state_out=638293c31bfc33f5c4eeacea4bc12816.
2. Single word: word_in=cf4f3c09.
   -> word_done in c+2; word_out=8a84eb01; state_out unchanged.
3. Tie after reset (WORD_FIRST=1): both valid held, state 00112233..eeff and word cf4f3c09.
   -> word accepted first (done c+2).
   -> state accepted at c+3 (state_done c+8).
   -> next tie goes to word (round-robin alternation verified over 4 jobs).
4. Valid held during busy: word_valid asserted in cycle c+2 of a state job.
   -> word_ready=0 until IDLE in c+6; accepted then; word_done c+8; no pulse lost or duplicated.
5. Reset mid-operation: rst_n=0 in cycle c+3 of a state job.
   -> next cycle: FSM IDLE, busy=0, state_out=0, no state_done pulse; a fresh request afterwards completes normally.
6. Input change after accept: state_in toggled to ffff...ff in cycle c+1.
   -> result still 638293c31bfc33f5c4eeacea4bc12816. All-ff state later -> 16 repeated 16 times; all-00 -> 63 repeated 16 times.
